// File: rtl/blit_scheduler.sv
// blit_scheduler: queues CPU blit commands and issues them one at a time to the blitter.
//   clk, reset_n          : clock, synchronous active-low reset
//   cmd_valid/cmd_ready   : command push handshake; cmd_op/src/height/x/y are the operands
//   cmd_sync              : hold the command until vertical blanking
//   cmd_flush             : drop every queued, not-yet-issued command
//   vblank                : vertical blanking level from video
//   blt_*                 : operand/enable outputs to the blitter, ready/collision back from it
//   collision, done, idle : last sprite collision result, completion pulse, scheduler empty
module blit_scheduler #(
    parameter int         DEPTH             = 4,
    parameter logic [2:0] BLIT_OP_SPRITE    = 3'd1,
    parameter logic [2:0] BLIT_OP_SPRITE_16 = 3'd2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [11:0] cmd_src,
    input  logic [3:0]  cmd_height,
    input  logic [6:0]  cmd_x,
    input  logic [5:0]  cmd_y,
    input  logic        cmd_sync,
    input  logic        cmd_flush,
    input  logic        vblank,
    output logic [2:0]  blt_operation,
    output logic [11:0] blt_src,
    output logic [3:0]  blt_height,
    output logic [6:0]  blt_destX,
    output logic [5:0]  blt_destY,
    output logic        blt_enable,
    input  logic        blt_ready,
    input  logic        blt_collision,
    output logic        collision,
    output logic        done,
    output logic        idle
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    typedef enum logic [2:0] {IDLE, WAIT_SYNC, START, BUSY, RELEASE} state_t;
    state_t        state_q, state_d;
    logic [32:0]   mem_q [DEPTH];
    logic [32:0]   head;
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   hold_q;
    logic          ready_q, coll_q, push, pop, sprite;
    assign head = mem_q[rd_q];
    // A flush wins over both ends of the queue: the same-cycle push is dropped and nothing is popped.
    assign push = cmd_valid && ready_q && !cmd_flush;
    assign pop = state_q == IDLE && count_q != '0 && blt_ready && !cmd_flush;
    assign count_d = cmd_flush ? '0 : count_q + CW'(push) - CW'(pop);
    assign sprite = hold_q[31:29] == BLIT_OP_SPRITE || hold_q[31:29] == BLIT_OP_SPRITE_16;
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = pop ? (head[0] ? WAIT_SYNC : START) : IDLE;
            WAIT_SYNC: state_d = vblank ? START : WAIT_SYNC;
            START:     state_d = blt_ready ? START : BUSY;
            BUSY:      state_d = blt_ready ? RELEASE : BUSY;
            default:   state_d = IDLE;
        endcase
    end
    // Control outputs are forced low while reset is held, even before the first reset edge.
    always_comb begin
        blt_enable = reset_n && (state_q == START || state_q == BUSY);
        done = reset_n && state_q == BUSY && blt_ready;
        idle = state_q == IDLE && count_q == '0;
        cmd_ready = reset_n && ready_q;
        collision = reset_n && coll_q;
        {blt_operation, blt_src, blt_height, blt_destX, blt_destY} = hold_q;
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {cmd_op, cmd_src, cmd_height, cmd_x, cmd_y, cmd_sync};
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            coll_q <= 1'b0;
            hold_q <= '0;
        end else begin
            count_q <= count_d;
            ready_q <= count_d != CW'(DEPTH);
            wr_q <= wr_q + AW'(push);
            rd_q <= cmd_flush ? wr_q : rd_q + AW'(pop);
            if (pop) hold_q <= head[32:1];
            if (state_q == BUSY && blt_ready && sprite) coll_q <= blt_collision;
        end
    end
endmodule

// File: doc/blit_scheduler.md
BLIT_SCHEDULER -- requirements
Module: blit_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command queue depth in entries (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port cmd_valid, input, 1, CPU offers a blit command.
REQ-005 SHALL have port cmd_ready, output, 1, queue can accept a command.
REQ-006 SHALL have ports cmd_op (3), cmd_src (12), cmd_height (4), cmd_x (7), cmd_y (6), all inputs: operation code per blitter.vh, source address, sprite rows, destination X, destination Y.
REQ-007 SHALL have port cmd_sync, input, 1, command waits for vblank before issue.
REQ-008 SHALL have port cmd_flush, input, 1, discard all queued, not-yet-issued commands.
REQ-009 SHALL have port vblank, input, 1, level-high vertical blanking from video.
REQ-010 SHALL have ports blt_operation (3), blt_src (12), blt_height (4), blt_destX (7), blt_destY (6), blt_enable (1), all outputs, driving the blitter.
REQ-011 SHALL have ports blt_ready and blt_collision, inputs, 1 each, from the blitter.
REQ-012 SHALL have port collision, output, 1, result of the last completed sprite op.
REQ-013 SHALL have port done, output, 1, one-cycle pulse per completed command.
REQ-014 SHALL have port idle, output, 1, high when the queue is empty and the FSM is in IDLE.

Function
REQ-015 Queue SHALL be a DEPTH-entry FIFO of {op, src, height, x, y, sync}; push when cmd_valid && cmd_ready; cmd_ready = !full, registered.
REQ-016 Pushed entry SHALL be visible to the FSM no earlier than the cycle after the push; push into an empty queue never issues in the same cycle.
REQ-017 Pointers SHALL wrap modulo DEPTH; occupancy counter DEPTH+1 states; push and pop in the same cycle leave occupancy unchanged.
REQ-018 cmd_flush SHALL empty the queue next cycle; an in-flight command completes normally; a push in the same cycle as flush is dropped.
REQ-019 FSM states SHALL be IDLE, WAIT_SYNC, START, BUSY, RELEASE.
REQ-020 IDLE: if queue non-empty and blt_ready=1, pop head into the blt_* holding registers; go to WAIT_SYNC if sync=1, else START.
REQ-021 WAIT_SYNC: go to START on the first cycle vblank=1; if vblank is already high, go to START the next cycle.
REQ-022 START: blt_enable=1; go to BUSY when blt_ready=0 (accepted).
REQ-023 BUSY: blt_enable=1; when blt_ready=1, latch blt_collision into collision if blt_operation is BLIT_OP_SPRITE or BLIT_OP_SPRITE_16, else keep collision unchanged; pulse done; go to RELEASE.
REQ-024 RELEASE: blt_enable=0 for exactly one cycle, then IDLE.
REQ-025 blt_* operand outputs SHALL stay stable from pop until RELEASE exits.
REQ-026 Minimum spacing SHALL be two cycles with blt_enable low between consecutive commands.
REQ-027 Unknown op codes SHALL be issued unchanged; the scheduler does not decode them except for the collision rule.

Reset
REQ-028 reset_n=0 SHALL set FSM=IDLE, empty the queue, and drive blt_enable=0, collision=0, done=0, cmd_ready=0 during reset, then cmd_ready=1 the cycle after release, idle=1, and all blt_* operands=0.
REQ-029 A reset during BUSY SHALL abandon tracking; after reset, IDLE issues nothing until blt_ready=1, so the blitter finishes its in-progress op first.

Verification
VER-001 Single CLEAR, cmd_sync=0, blitter model: start 2 cycles after push; blt_enable held until blt_ready rises; done pulses once; idle=1 after RELEASE.
VER-002 DEPTH=4: push 5 commands back-to-back while the blitter is busy; cmd_ready falls after the 4th; the 5th is accepted after the first pop; all 5 issue in order with operands intact.
VER-003 Sprite op with blt_collision=1, then SCROLL_LEFT with blt_collision=0: collision=1 after both ops; a second sprite with collision 0 gives collision=0.
VER-004 cmd_sync=1 with vblank low for 100 cycles: blt_enable stays 0 until vblank rises, then asserts next cycle.
VER-005 Queue of 3, flush asserted while the first is BUSY: the first completes with a done pulse; the other two never issue; idle=1.
VER-006 reset_n pulsed low mid-BUSY with blt_ready=0 held for 10 more cycles and a queued command: no blt_enable until blt_ready=1; the queued command is lost.
